// File: rtl/step_sequencer.sv
//------------------------------------------------------------------------------
// step_sequencer
//
// Walks a 4-entry table of {index, dwell} entries. Each step is held for
// dwell+1 cycles. After the last step the sequencer either wraps to step 0
// (loop_en=1) or returns to IDLE with a one-cycle done pulse. The table is
// writable only while IDLE and reloads its defaults on reset.
//
// Ports
//   clk        in   clock, rising-edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run request (accepted in IDLE when stop is low)
//   stop       in   abort request (wins over start and over any advance)
//   loop_en    in   wrap from last step to step 0, sampled at last-step expiry
//   cfg_we     in   table write strobe (IDLE only)
//   cfg_addr   in   table entry select
//   cfg_index  in   index value for the selected entry
//   cfg_dwell  in   dwell value for the selected entry
//   step       out  current step pointer
//   index      out  index value of the current step
//   step_valid out  one-cycle pulse on each step entry
//   busy       out  high while in RUN
//   done       out  one-cycle pulse on normal completion
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module step_sequencer #(
    parameter int NSTEP = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [3:0]    cfg_index,
    input  logic [DW-1:0] cfg_dwell,
    output logic [1:0]    step,
    output logic [3:0]    index,
    output logic          step_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q;
    logic [1:0]    step_q;
    logic [3:0]    index_q;
    logic          step_valid_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] cnt_q;
    logic [3:0]    tbl_index_q [NSTEP];
    logic [DW-1:0] tbl_dwell_q [NSTEP];

    logic [1:0]    step_d;

    assign step_d = step_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            step_q         <= 2'd0;
            index_q        <= 4'd0;
            step_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cnt_q          <= '0;
            tbl_index_q[0] <= 4'd5;
            tbl_index_q[1] <= 4'd12;
            tbl_index_q[2] <= 4'd7;
            tbl_index_q[3] <= 4'd0;
            for (int i = 0; i < NSTEP; i++) begin
                tbl_dwell_q[i] <= '0;
            end
        end else begin
            // Both pulses default low; only the transitions below raise them.
            step_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_we) begin
                        tbl_index_q[cfg_addr] <= cfg_index;
                        tbl_dwell_q[cfg_addr] <= cfg_dwell;
                    end
                    if (start && !stop) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        step_q       <= 2'd0;
                        index_q      <= tbl_index_q[0];
                        step_valid_q <= 1'b1;
                        cnt_q        <= tbl_dwell_q[0];
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DW'(1);
                    end else if (step_q != 2'(NSTEP - 1)) begin
                        step_q       <= step_d;
                        index_q      <= tbl_index_q[step_d];
                        step_valid_q <= 1'b1;
                        cnt_q        <= tbl_dwell_q[step_d];
                    end else if (loop_en) begin
                        step_q       <= 2'd0;
                        index_q      <= tbl_index_q[0];
                        step_valid_q <= 1'b1;
                        cnt_q        <= tbl_dwell_q[0];
                    end else begin
                        // Normal completion: step/index keep their last values.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign step       = step_q;
    assign index      = index_q;
    assign step_valid = step_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_step_sequencer.sv
`timescale 1ns/1ps
module tb_step_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [3:0] cfg_index = 4'd0;
    logic [7:0] cfg_dwell = 8'd0;
    logic [1:0] step;
    logic [3:0] index;
    logic       step_valid;
    logic       busy;
    logic       done;

    int n_pass = 0;
    int n_total = 0;

    step_sequencer #(.NSTEP(4), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_index(cfg_index), .cfg_dwell(cfg_dwell),
        .step(step), .index(index), .step_valid(step_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks all outputs; step=-1 skips the step check.
    task automatic chk(input string tag, input int e_step, input int e_index,
                       input int e_valid, input int e_busy, input int e_done);
        if (e_step >= 0) check({tag, ".step"}, int'(step), e_step);
        check({tag, ".index"}, int'(index), e_index);
        check({tag, ".step_valid"}, int'(step_valid), e_valid);
        check({tag, ".busy"}, int'(busy), e_busy);
        check({tag, ".done"}, int'(done), e_done);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [3:0] ix, input logic [7:0] dw);
        cfg_we = 1'b1; cfg_addr = a; cfg_index = ix; cfg_dwell = dw;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_idle", 0, 0, 0, 0, 0);

        // Default run, loop_en=0
        pulse_start();
        chk("def_e1", 0, 5, 1, 1, 0);
        tick(); chk("def_e2", 1, 12, 1, 1, 0);
        tick(); chk("def_e3", 2, 7, 1, 1, 0);
        tick(); chk("def_e4", 3, 0, 1, 1, 0);
        tick(); chk("def_done", 3, 0, 0, 0, 1);
        tick(); chk("def_after", 3, 0, 0, 0, 0);

        // Entry1 dwell=2: step 1 held 3 cycles, 6 busy cycles
        cfg_write(2'd1, 4'd12, 8'd2);
        pulse_start();
        chk("dw_s0", 0, 5, 1, 1, 0);
        tick(); chk("dw_s1a", 1, 12, 1, 1, 0);
        tick(); chk("dw_s1b", 1, 12, 0, 1, 0);
        tick(); chk("dw_s1c", 1, 12, 0, 1, 0);
        tick(); chk("dw_s2", 2, 7, 1, 1, 0);
        tick(); chk("dw_s3", 3, 0, 1, 1, 0);
        tick(); chk("dw_done", 3, 0, 0, 0, 1);
        cfg_write(2'd1, 4'd12, 8'd0);

        // Loop mode, then stop during the second pass
        loop_en = 1'b1;
        pulse_start();
        chk("lp_s0", 0, 5, 1, 1, 0);
        tick(); tick(); tick();
        chk("lp_s3", 3, 0, 1, 1, 0);
        tick(); chk("lp_wrap", 0, 5, 1, 1, 0);
        tick(); chk("lp_2nd_s1", 1, 12, 1, 1, 0);
        stop = 1'b1;
        tick(); chk("lp_stop", -1, 12, 0, 0, 0);
        stop = 1'b0; loop_en = 1'b0;
        tick(); chk("lp_stop_nodone", -1, 12, 0, 0, 0);

        // Table write while busy is ignored
        pulse_start();
        cfg_write(2'd2, 4'd9, 8'd0);
        tick(); chk("wbusy_s2", 2, 7, 1, 1, 0);
        tick(); tick();
        chk("wbusy_done", 3, 0, 0, 0, 1);
        pulse_start();
        tick(); tick(); chk("wbusy_next_s2", 2, 7, 1, 1, 0);
        tick(); tick();
        // Write in IDLE takes effect on the next run
        cfg_write(2'd2, 4'd9, 8'd0);
        pulse_start();
        tick(); tick(); chk("widle_s2", 2, 9, 1, 1, 0);
        tick(); tick();

        // Asynchronous reset during step 2
        pulse_start();
        tick(); tick(); chk("ar_s2", 2, 9, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1 chk("ar_async", 0, 0, 0, 0, 0);
        tick(); chk("ar_held", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick(); chk("ar_release", 0, 0, 0, 0, 0);
        pulse_start();
        chk("ar_restart", 0, 5, 1, 1, 0);
        tick(); tick(); chk("ar_default_s2", 2, 7, 1, 1, 0);
        tick(); tick(); chk("ar_done", 3, 0, 0, 0, 1);

        // start and stop together in IDLE; start accepted in done cycle is covered below
        start = 1'b1; stop = 1'b1;
        tick(); chk("ss_1", -1, 0, 0, 0, 0);
        tick(); chk("ss_2", -1, 0, 0, 0, 0);
        start = 1'b0; stop = 1'b0;

        // start while done is high is accepted
        pulse_start();
        tick(); tick(); tick();
        chk("dn_s3", 3, 0, 1, 1, 0);
        tick(); chk("dn_done", 3, 0, 0, 0, 1);
        start = 1'b1;
        tick(); start = 1'b0;
        chk("dn_restart", 0, 5, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter: NSTEP, 4, number of table steps (fixed at 4; step pointer 2 bits).
REQ-002 Parameter: DW, 8, dwell counter width.
REQ-003 Port: clk  input  1  clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  run request, sampled each cycle.
REQ-006 Port: stop  input  1  abort request, sampled each cycle.
REQ-007 Port: loop_en  input  1  1 = wrap from last step to step 0; sampled at last-step expiry.
REQ-008 Port: cfg_we  input  1  table write strobe.
REQ-009 Port: cfg_addr  input  2  table entry select.
REQ-010 Port: cfg_index  input  4  index value for the selected entry.
REQ-011 Port: cfg_dwell  input  DW  dwell value for the selected entry.
REQ-012 Port: step  output  2  current step pointer.
REQ-013 Port: index  output  4  index value of the current step.
REQ-014 Port: step_valid  output  1  one-cycle pulse on each step entry.
REQ-015 Port: busy  output  1  high while in RUN.
REQ-016 Port: done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 The block SHALL implement two states, IDLE and RUN, plus a 4-entry table of {index[3:0], dwell[DW-1:0]}.
REQ-018 A step SHALL be held for dwell+1 cycles; dwell 0 gives one cycle per step.
REQ-019 In IDLE, cfg_we SHALL write cfg_index/cfg_dwell into entry cfg_addr at the clock edge.
REQ-020 In RUN, cfg_we SHALL be ignored and the table SHALL be unchanged.
REQ-021 IDLE with start=1 and stop=0 at edge N SHALL give, from edge N+1: RUN, busy=1, step=0, index=entry0.index, step_valid=1, and the dwell counter loaded with entry0.dwell.
REQ-022 In RUN with counter>0, the counter SHALL decrement; step, index and step_valid=0 SHALL hold.
REQ-023 In RUN with counter=0 and step<3, the next cycle SHALL have step+1, its index, step_valid=1 and the counter reloaded.
REQ-024 In RUN with counter=0, step=3 and loop_en=1, the next cycle SHALL have step=0, index=entry0.index, step_valid=1 and busy remaining 1.
REQ-025 In RUN with counter=0, step=3 and loop_en=0, the next cycle SHALL have IDLE, busy=0, done=1 for exactly one cycle, step_valid=0, and step/index held at their last values.
REQ-026 In RUN, stop=1 SHALL force IDLE next cycle with busy=0, done=0 and step_valid=0, taking priority over any advance.
REQ-027 start while in RUN SHALL be ignored.
REQ-028 start and stop both high in IDLE: stop wins and the block SHALL stay in IDLE.
REQ-029 done and step_valid SHALL never be high in the same cycle.
REQ-030 A new start in the cycle that done is high SHALL be accepted normally, since the block is already in IDLE.

Reset
REQ-031 rst_n low SHALL immediately, independent of clk, force: IDLE, step=0, index=0, step_valid=0, busy=0, done=0 and dwell counter=0.
REQ-032 Reset SHALL load table defaults: index {5,12,7,0} for entries 0..3 and dwell 0 for all entries.
REQ-033 Reset asserted mid-run SHALL abort without a done pulse.
REQ-034 After rst_n deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-035 Reset defaults, loop_en=0, start pulse at edge 0 -> index 5,12,7,0 on edges 1-4, step_valid high on each of those edges, done=1 on edge 5 only, busy low from edge 5.
REQ-036 Write entry1 dwell=2 in IDLE, then start -> step 1 (index 12) held 3 cycles with step_valid only on its first cycle; total run 6 cycles.
REQ-037 loop_en=1, defaults -> after index 0 the sequence returns to index 5 with step_valid=1 and no done; stop during the second pass -> busy=0 next cycle and no done.
REQ-038 cfg_we to entry2 with index=9 while busy -> entry2 still reads back 7 on the next run; the same write in IDLE -> next run shows 9.
REQ-039 rst_n pulsed low during step 2 -> outputs zero asynchronously, no done; after release, start -> sequence restarts at index 5.
REQ-040 start and stop high together in IDLE -> busy stays 0 and step_valid stays 0.
